// File: rtl/led_matrix_scanner.sv
// Column-scan driver for a 16x16 LED matrix.
// Double-buffered patterns swap only at frame wrap, so frames never tear.
module led_matrix_scanner #(
    parameter int CLK_DIV = 1000,
    parameter int BLANK   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [255:0] pattern,
    input  logic         load,
    output logic [15:0]  col_sel,
    output logic [15:0]  row_data,
    output logic         frame_done,
    output logic         load_ack
);

    localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] BLANK_T  = TW'(BLANK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BLANK,
        S_DRIVE
    } state_t;

    state_t         r_state;
    logic [3:0]     r_col;
    logic [TW-1:0]  r_tick;
    logic [255:0]   r_shadow;
    logic [255:0]   r_display;
    logic           r_pending;

    state_t         w_state_nxt;
    logic [3:0]     w_col_nxt;
    logic [TW-1:0]  w_tick_nxt;
    logic           w_wrap;
    logic           w_swap;
    logic           w_pending_nxt;
    logic [255:0]   w_disp_nxt;
    logic [15:0]    w_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_col   <= 4'd0;
            r_tick  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_tick  <= w_tick_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_tick_nxt  = r_tick;
        w_wrap      = 1'b0;
        if (!en) begin
            w_state_nxt = S_IDLE;
            w_col_nxt   = 4'd0;
            w_tick_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_col_nxt   = 4'd0;
                    w_tick_nxt  = '0;
                    w_state_nxt = (BLANK > 0) ? S_BLANK : S_DRIVE;
                end
                default: begin
                    if (r_tick == TICK_MAX) begin
                        w_tick_nxt = '0;
                        w_col_nxt  = r_col + 4'd1;
                        w_wrap     = (r_col == 4'hF);
                    end else begin
                        w_tick_nxt = r_tick + 1'b1;
                    end
                    w_state_nxt = (w_tick_nxt < BLANK_T) ? S_BLANK : S_DRIVE;
                end
            endcase
        end
    end

    // A load on the swap edge refills shadow and keeps pending set.
    always_comb begin
        w_swap        = r_pending && (w_wrap || (r_state == S_IDLE));
        w_pending_nxt = load | (r_pending & ~w_swap);
        w_disp_nxt    = w_swap ? r_shadow : r_display;
        w_row         = w_disp_nxt[{w_col_nxt, 4'b0000} +: 16];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow  <= '0;
            r_display <= '0;
            r_pending <= 1'b0;
        end else begin
            if (load) begin
                r_shadow <= pattern;
            end
            r_display <= w_disp_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_sel    <= 16'h0;
            row_data   <= 16'h0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            col_sel    <= (w_state_nxt == S_DRIVE) ? (16'h1 << w_col_nxt) : 16'h0;
            row_data   <= (w_state_nxt == S_DRIVE) ? w_row : 16'h0;
            frame_done <= w_wrap;
            load_ack   <= w_swap;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner with CLK_DIV=4, BLANK=1.
// One slot = 1 dark + 3 drive cycles; a frame = 64 cycles.
module tb_led_matrix_scanner;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         load;
    logic [255:0] pattern;
    logic [15:0]  col_sel;
    logic [15:0]  row_data;
    logic         frame_done;
    logic         load_ack;

    int           n_chk  = 0;
    int           n_fail = 0;
    int           pos;
    logic [255:0] exp_disp;
    logic [255:0] nxt_disp;
    bit           ack_due;
    logic [255:0] pat_a, pat_b, pat_c, pat_d;

    led_matrix_scanner #(
        .CLK_DIV(4),
        .BLANK  (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pattern   (pattern),
        .load      (load),
        .col_sel   (col_sel),
        .row_data  (row_data),
        .frame_done(frame_done),
        .load_ack  (load_ack)
    );

    always #5 clk = ~clk;

    task automatic expect_eq(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] word(logic [255:0] p, int k);
        return p[16*k +: 16];
    endfunction

    // Advance n cycles, checking the expected scan position each cycle.
    task automatic run(int n);
        logic [15:0] e_sel;
        logic [15:0] e_row;
        for (int i = 0; i < n; i++) begin
            step;
            pos = (pos + 1) % 64;
            if (pos == 0 && ack_due) exp_disp = nxt_disp;
            e_sel = (pos % 4 != 0) ? 16'(1 << (pos / 4)) : 16'h0;
            e_row = (pos % 4 != 0) ? word(exp_disp, pos / 4) : 16'h0;
            expect_eq($sformatf("col_sel@%0d", pos), 32'(col_sel), 32'(e_sel));
            expect_eq($sformatf("row@%0d", pos), 32'(row_data), 32'(e_row));
            expect_eq($sformatf("fdone@%0d", pos), 32'(frame_done),
                      32'(pos == 0));
            expect_eq($sformatf("ack@%0d", pos), 32'(load_ack),
                      32'(pos == 0 && ack_due));
            if (pos == 0) ack_due = 1'b0;
        end
    endtask

    initial begin
        int fd_cnt;
        int fd_first;
        int fd_second;

        pat_a = '0;
        pat_a[16*7 +: 16] = 16'h3FFC;
        pat_b = '0;
        pat_b[16*5 +: 16]  = 16'h5555;
        pat_b[16*6 +: 16]  = 16'hAAAA;
        pat_b[16*12 +: 16] = 16'h1234;
        pat_c = '0;
        pat_c[16*0 +: 16] = 16'h8001;
        pat_c[16*2 +: 16] = 16'hC003;
        pat_c[16*6 +: 16] = 16'h0F0F;
        pat_d = '0;
        pat_d[16*0 +: 16]  = 16'h00F0;
        pat_d[16*1 +: 16]  = 16'hFFFF;
        pat_d[16*15 +: 16] = 16'h8001;

        rst_n    = 1'b0;
        en       = 1'b1;
        load     = 1'b0;
        pattern  = '0;
        exp_disp = '0;
        nxt_disp = '0;
        ack_due  = 1'b0;
        pos      = 0;

        repeat (3) step;
        expect_eq("rst_col_sel", 32'(col_sel), 32'h0);
        expect_eq("rst_row", 32'(row_data), 32'h0);
        expect_eq("rst_fdone", 32'(frame_done), 32'h0);
        expect_eq("rst_ack", 32'(load_ack), 32'h0);

        en = 1'b0;
        step;
        rst_n = 1'b1;
        step;

        pattern = pat_a;
        load    = 1'b1;
        step;
        load = 1'b0;
        expect_eq("idle_ack_early", 32'(load_ack), 32'h0);
        step;
        expect_eq("idle_ack", 32'(load_ack), 32'h1);
        expect_eq("idle_fdone", 32'(frame_done), 32'h0);
        expect_eq("idle_col_sel", 32'(col_sel), 32'h0);
        step;
        expect_eq("idle_ack_once", 32'(load_ack), 32'h0);

        exp_disp = pat_a;
        en = 1'b1;
        step;
        pos = 0;
        expect_eq("entry_col_sel", 32'(col_sel), 32'h0);
        expect_eq("entry_row", 32'(row_data), 32'h0);
        expect_eq("entry_fdone", 32'(frame_done), 32'h0);
        run(63);

        fd_cnt    = 0;
        fd_first  = -1;
        fd_second = -1;
        for (int i = 0; i < 128; i++) begin
            run(1);
            if (frame_done) begin
                fd_cnt++;
                if (fd_first < 0) fd_first = i;
                else if (fd_second < 0) fd_second = i;
            end
        end
        expect_eq("fdone_count", 32'(fd_cnt), 32'd2);
        expect_eq("fdone_period", 32'(fd_second - fd_first), 32'd64);

        run(22);
        pattern = pat_b;
        load    = 1'b1;
        run(1);
        load     = 1'b0;
        nxt_disp = pat_b;
        ack_due  = 1'b1;
        run(42);
        run(63);

        run(11);
        pattern = pat_d;
        load    = 1'b1;
        run(1);
        load = 1'b0;
        run(19);
        pattern = pat_c;
        load    = 1'b1;
        run(1);
        load     = 1'b0;
        nxt_disp = pat_c;
        ack_due  = 1'b1;
        run(33);
        run(64);

        run(10);
        pattern = pat_b;
        load    = 1'b1;
        run(1);
        load = 1'b0;
        run(52);
        nxt_disp = pat_b;
        ack_due  = 1'b1;
        pattern  = pat_d;
        load     = 1'b1;
        run(1);
        load     = 1'b0;
        nxt_disp = pat_d;
        ack_due  = 1'b1;
        run(64);

        run(37);
        en = 1'b0;
        step;
        expect_eq("dis_col_sel", 32'(col_sel), 32'h0);
        expect_eq("dis_row", 32'(row_data), 32'h0);
        expect_eq("dis_fdone", 32'(frame_done), 32'h0);
        step;
        expect_eq("dis_col_sel2", 32'(col_sel), 32'h0);
        en = 1'b1;
        step;
        pos = 0;
        expect_eq("reen_blank", 32'(col_sel), 32'h0);
        run(1);
        expect_eq("reen_col0", 32'(col_sel), 32'h0001);
        expect_eq("reen_row0", 32'(row_data), 32'h00F0);
        run(3);

        pattern = pat_b;
        load    = 1'b1;
        run(1);
        load = 1'b0;
        run(1);
        #1;
        rst_n = 1'b0;
        #1;
        expect_eq("async_col_sel", 32'(col_sel), 32'h0);
        expect_eq("async_row", 32'(row_data), 32'h0);
        step;
        step;
        rst_n = 1'b1;
        step;
        pos      = 0;
        exp_disp = '0;
        ack_due  = 1'b0;
        expect_eq("post_rst_col_sel", 32'(col_sel), 32'h0);
        run(64);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
